// File: rtl/fft16_output_reorder.sv
// fft16_output_reorder: converts 4-lane radix-4 FFT beats into a natural-order serial bin stream
// using two ping-pong frame banks.
module fft16_output_reorder #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_0_real,
    input  logic [DATA_W-1:0] in_1_real,
    input  logic [DATA_W-1:0] in_2_real,
    input  logic [DATA_W-1:0] in_3_real,
    input  logic [DATA_W-1:0] in_0_im,
    input  logic [DATA_W-1:0] in_1_im,
    input  logic [DATA_W-1:0] in_2_im,
    input  logic [DATA_W-1:0] in_3_im,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_real,
    output logic [DATA_W-1:0] out_im,
    output logic [3:0]        out_index,
    output logic              out_last
);
    logic [2*DATA_W-1:0] mem [0:31];
    logic [1:0] full, set_m, clr_m, wbeat;
    logic       wbank, rbank, in_acc, out_acc;
    logic [3:0] ridx;

    always_comb begin
        in_ready  = !full[wbank];
        out_valid = full[rbank];
        in_acc    = in_valid && in_ready;
        out_acc   = out_valid && out_ready;
        // set and clear can never hit the same bank: set needs it empty, clear needs it full
        set_m     = (in_acc && wbeat == 2'd3) ? (wbank ? 2'b10 : 2'b01) : 2'b00;
        clr_m     = (out_acc && ridx == 4'd15) ? (rbank ? 2'b10 : 2'b01) : 2'b00;
        {out_real, out_im} = out_valid ? mem[{rbank, ridx}] : '0;
        out_index = ridx;
        out_last  = out_valid && ridx == 4'd15;
    end

    // lane l of beat b holds bin 4*l+b
    always_ff @(posedge clk) begin
        if (in_acc) begin
            mem[{wbank, 2'd0, wbeat}] <= {in_0_real, in_0_im};
            mem[{wbank, 2'd1, wbeat}] <= {in_1_real, in_1_im};
            mem[{wbank, 2'd2, wbeat}] <= {in_2_real, in_2_im};
            mem[{wbank, 2'd3, wbeat}] <= {in_3_real, in_3_im};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full  <= 2'b00;
            wbank <= 1'b0;
            wbeat <= 2'd0;
            rbank <= 1'b0;
            ridx  <= 4'd0;
        end else begin
            if (in_acc) begin
                wbeat <= wbeat + 2'd1;
                if (wbeat == 2'd3) wbank <= ~wbank;
            end
            if (out_acc) begin
                ridx <= ridx + 4'd1;
                if (ridx == 4'd15) rbank <= ~rbank;
            end
            full <= (full | set_m) & ~clr_m;
        end
    end
endmodule

// File: tb/tb_fft16_output_reorder.sv
// tb_fft16_output_reorder: directed checks of frame reordering, ping-pong flow control and reset.
module tb_fft16_output_reorder;
    logic        clk = 0, reset = 1, in_valid = 0, out_ready = 0;
    logic        in_ready, out_valid, out_last;
    logic [31:0] in_0_real = 0, in_1_real = 0, in_2_real = 0, in_3_real = 0;
    logic [31:0] in_0_im = 0, in_1_im = 0, in_2_im = 0, in_3_im = 0;
    logic [31:0] out_real, out_im;
    logic [3:0]  out_index;
    int tests = 0, fails = 0;

    fft16_output_reorder #(.DATA_W(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_0_real(in_0_real), .in_1_real(in_1_real), .in_2_real(in_2_real), .in_3_real(in_3_real),
        .in_0_im(in_0_im), .in_1_im(in_1_im), .in_2_im(in_2_im), .in_3_im(in_3_im),
        .out_valid(out_valid), .out_ready(out_ready), .out_real(out_real), .out_im(out_im),
        .out_index(out_index), .out_last(out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // bin k of a frame with base B: real = B+k, im = B+0x100+k
    task automatic drive_beat(input logic [31:0] base, input int b);
        in_0_real = base + 32'(b);      in_0_im = base + 32'h100 + 32'(b);
        in_1_real = base + 32'(4 + b);  in_1_im = base + 32'h100 + 32'(4 + b);
        in_2_real = base + 32'(8 + b);  in_2_im = base + 32'h100 + 32'(8 + b);
        in_3_real = base + 32'(12 + b); in_3_im = base + 32'h100 + 32'(12 + b);
        in_valid = 1;
    endtask

    task automatic send_beat(input logic [31:0] base, input int b);
        int n = 0;
        drive_beat(base, b);
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        chk($sformatf("in_ready_wait_b%0d", b), {31'b0, in_ready}, 1);
        tick();
    endtask

    task automatic check_bin(input string tag, input logic [31:0] base, input int k);
        chk($sformatf("%s_valid_k%0d", tag, k), {31'b0, out_valid}, 1);
        chk($sformatf("%s_index_k%0d", tag, k), {28'b0, out_index}, 32'(k));
        chk($sformatf("%s_real_k%0d", tag, k), out_real, base + 32'(k));
        chk($sformatf("%s_im_k%0d", tag, k), out_im, base + 32'h100 + 32'(k));
        chk($sformatf("%s_last_k%0d", tag, k), {31'b0, out_last}, {31'b0, k == 15});
    endtask

    task automatic drain(input string tag, input logic [31:0] base, input int stall_at, input int stall_len);
        out_ready = 1;
        for (int k = 0; k < 16; k++) begin
            check_bin(tag, base, k);
            if (k == stall_at) begin
                out_ready = 0;
                for (int s = 0; s < stall_len; s++) begin
                    tick();
                    check_bin({tag, "_held"}, base, k);
                end
                out_ready = 1;
            end
            tick();
        end
    endtask

    task automatic do_reset();
        in_valid = 0;
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    initial begin
        // reset values
        do_reset();
        chk("rst_in_ready", {31'b0, in_ready}, 1);
        chk("rst_out_valid", {31'b0, out_valid}, 0);
        chk("rst_out_real", out_real, 0);
        chk("rst_out_im", out_im, 0);
        chk("rst_out_index", {28'b0, out_index}, 0);
        chk("rst_out_last", {31'b0, out_last}, 0);

        // single frame with one-cycle latency after the last beat
        out_ready = 1;
        for (int b = 0; b < 4; b++) begin
            if (b == 3) chk("single_novalid_before_b3", {31'b0, out_valid}, 0);
            send_beat(32'h100, b);
        end
        in_valid = 0;
        drain("single", 32'h100, 16, 0);
        chk("single_valid_after", {31'b0, out_valid}, 0);

        // back-to-back frames A and B with continuous output
        do_reset();
        out_ready = 1;
        for (int cyc = 1; cyc <= 36; cyc++) begin
            if (cyc <= 8) drive_beat(cyc <= 4 ? 32'h1000 : 32'h2000, (cyc - 1) % 4);
            else in_valid = 0;
            tick();
            if (cyc == 8 || cyc == 19) chk($sformatf("b2b_in_ready_low_c%0d", cyc), {31'b0, in_ready}, 0);
            if (cyc == 20) chk("b2b_in_ready_back", {31'b0, in_ready}, 1);
            if (cyc >= 4 && cyc <= 35) check_bin(cyc < 20 ? "b2b_A" : "b2b_B", cyc < 20 ? 32'h1000 : 32'h2000, (cyc - 4) % 16);
        end
        chk("b2b_valid_after", {31'b0, out_valid}, 0);

        // output backpressure at index 5
        do_reset();
        out_ready = 1;
        for (int b = 0; b < 4; b++) send_beat(32'h100, b);
        in_valid = 0;
        drain("bp", 32'h100, 5, 3);
        chk("bp_valid_after", {31'b0, out_valid}, 0);

        // input stall between beats 1 and 2
        do_reset();
        out_ready = 1;
        for (int b = 0; b < 4; b++) begin
            send_beat(32'h100, b);
            if (b == 1) begin
                in_valid = 0;
                tick();
                tick();
            end
        end
        in_valid = 0;
        drain("istall", 32'h100, 16, 0);

        // reset after two beats of A, then full frame B
        do_reset();
        out_ready = 1;
        send_beat(32'h3000, 0);
        send_beat(32'h3000, 1);
        do_reset();
        chk("midrst_out_valid", {31'b0, out_valid}, 0);
        chk("midrst_in_ready", {31'b0, in_ready}, 1);
        for (int b = 0; b < 4; b++) begin
            send_beat(32'h4000, b);
            if (b < 3) chk($sformatf("midrst_novalid_b%0d", b), {31'b0, out_valid}, 0);
        end
        in_valid = 0;
        drain("midrst_B", 32'h4000, 16, 0);
        chk("midrst_valid_after", {31'b0, out_valid}, 0);

        // both banks full, output stalled with input pending
        do_reset();
        out_ready = 0;
        for (int b = 0; b < 4; b++) send_beat(32'h5000, b);
        for (int b = 0; b < 4; b++) send_beat(32'h6000, b);
        drive_beat(32'h9000, 0);
        for (int c = 0; c < 20; c++) begin
            chk($sformatf("full_in_ready_c%0d", c), {31'b0, in_ready}, 0);
            chk($sformatf("full_index_c%0d", c), {28'b0, out_index}, 0);
            chk($sformatf("full_real_c%0d", c), out_real, 32'h5000);
            tick();
        end
        in_valid = 0;
        drain("full_A", 32'h5000, 16, 0);
        drain("full_B", 32'h6000, 16, 0);
        chk("full_valid_after", {31'b0, out_valid}, 0);
        for (int b = 0; b < 4; b++) send_beat(32'h7000, b);
        in_valid = 0;
        drain("full_C", 32'h7000, 16, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
